// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor result path: dumper FSM states,
// ASCII constants and the length clamp used when sampling a dump request.
package coproc_pkg;
  localparam int DUMP_ADDR_W = 10;
  localparam int DUMP_DEPTH  = 1024;

  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_D    = 8'h44;
  localparam logic [7:0] ASCII_E    = 8'h45;

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_CAP, S_SEND, S_GUARD, S_WAIT, S_NEXT, S_TRAIL, S_FIN
  } dump_state_t;

  function automatic int unsigned clamp_len(input int unsigned n, input int unsigned depth);
    return (n > depth) ? depth : n;
  endfunction
endpackage

// File: rtl/byte_to_dec_ascii.sv
// Combinational byte -> unsigned decimal ASCII digits plus significant-digit count.
module byte_to_dec_ascii
  import coproc_pkg::*;
(
  input  logic [7:0] v,
  output logic [7:0] d_hun,
  output logic [7:0] d_ten,
  output logic [7:0] d_one,
  output logic [1:0] ndig
);
  logic [1:0] hun;
  logic [7:0] rem, ten, one;

  always_comb begin
    if (v >= 8'd200) begin
      hun = 2'd2;
      rem = v - 8'd200;
    end else if (v >= 8'd100) begin
      hun = 2'd1;
      rem = v - 8'd100;
    end else begin
      hun = 2'd0;
      rem = v;
    end
    ten  = rem / 8'd10;
    one  = rem - ten * 8'd10;
    ndig = (v < 8'd10) ? 2'd1 : (v < 8'd100) ? 2'd2 : 2'd3;
  end

  assign d_hun = ASCII_ZERO + {6'd0, hun};
  assign d_ten = ASCII_ZERO + ten;
  assign d_one = ASCII_ZERO + one;
endmodule

// File: rtl/bram_dec_dumper.sv
// Reads len bytes from result BRAM port B and streams them to the UART as
// decimal ASCII lines, closing with "D\n".
module bram_dec_dumper
  import coproc_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DEPTH  = DUMP_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dout,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy
);
  localparam int CNT_W = ADDR_W + 1;

  dump_state_t       state;
  logic [CNT_W-1:0]  remaining, len_c;
  logic [ADDR_W-1:0] addr;
  logic              trail_sel;
  logic [3:0][7:0]   cbuf, cap_buf;
  logic [2:0]        char_cnt;
  logic [1:0]        idx, idx_nx;
  logic [7:0]        d_hun, d_ten, d_one;
  logic [1:0]        ndig;

  byte_to_dec_ascii u_conv (
    .v     (mem_dout),
    .d_hun (d_hun),
    .d_ten (d_ten),
    .d_one (d_one),
    .ndig  (ndig)
  );

  assign len_c  = CNT_W'(clamp_len(32'(len), DEPTH));
  assign idx_nx = idx + 2'd1;

  // Slot 0 is the first character on the wire; LF follows the last digit.
  always_comb begin
    cap_buf = '0;
    case (ndig)
      2'd3:    cap_buf = {ASCII_LF, d_one, d_ten, d_hun};
      2'd2:    cap_buf = {8'h00, ASCII_LF, d_one, d_ten};
      default: cap_buf = {16'h0000, ASCII_LF, d_one};
    endcase
  end

  // Request is decided in SEND itself so the first byte leaves three cycles after start.
  assign tx_start = (state == S_SEND) && !tx_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      remaining <= '0;
      addr      <= '0;
      trail_sel <= 1'b0;
      cbuf      <= '0;
      char_cnt  <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      tx_data   <= '0;
    end else begin
      done   <= 1'b0;
      mem_en <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          remaining <= len_c;
          addr      <= '0;
          trail_sel <= 1'b0;
          busy      <= 1'b1;
          if (len_c == '0) state <= S_TRAIL;
          else begin
            state    <= S_RD;
            mem_en   <= 1'b1;
            mem_addr <= '0;
          end
        end
        S_RD:  state <= S_CAP;
        S_CAP: begin
          cbuf     <= cap_buf;
          char_cnt <= {1'b0, ndig} + 3'd1;
          idx      <= '0;
          tx_data  <= cap_buf[0];
          state    <= S_SEND;
        end
        S_SEND:  if (!tx_busy) state <= S_GUARD;
        S_GUARD: state <= S_WAIT;
        S_WAIT: if (!tx_busy) begin
          if ({1'b0, idx} + 3'd1 < char_cnt) begin
            idx     <= idx_nx;
            tx_data <= cbuf[idx_nx];
            state   <= S_SEND;
          end else if (trail_sel) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end else begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          remaining <= remaining - CNT_W'(1);
          // Last byte leaves addr alone so it never steps past DEPTH-1.
          if (remaining == CNT_W'(1)) state <= S_TRAIL;
          else begin
            addr     <= addr + ADDR_W'(1);
            mem_addr <= addr + ADDR_W'(1);
            mem_en   <= 1'b1;
            state    <= S_RD;
          end
        end
        S_TRAIL: begin
          cbuf      <= {16'h0000, ASCII_LF, ASCII_D};
          char_cnt  <= 3'd2;
          idx       <= '0;
          trail_sel <= 1'b1;
          tx_data   <= ASCII_D;
          state     <= S_SEND;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_dec_dumper.sv
// Directed bench: BRAM and UART models, byte stream and address capture, checked
// against hand-written expected strings.
module tb_bram_dec_dumper;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [10:0] len;
  logic        busy, done, mem_en, tx_start, tx_busy;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_dout, tx_data;

  logic [7:0]  mem [1024];
  logic [7:0]  rxq [$];
  logic [9:0]  addrq [$];
  int          busy_len = 20;
  int          bcnt, dcnt, b2b, ovl, anz;
  logic        prev_ts;
  int          checks = 0, errors = 0;

  bram_dec_dumper dut (
    .clk(clk), .resetn(resetn), .start(start), .len(len), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_dout <= mem[mem_addr];

  // UART model: busy for busy_len cycles starting the cycle after tx_start.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_start) begin
      tx_busy <= 1'b1;
      bcnt    <= busy_len - 1;
    end else if (bcnt != 0) bcnt <= bcnt - 1;
    else tx_busy <= 1'b0;
  end

  always @(posedge clk) begin
    if (tx_start) rxq.push_back(tx_data);
    if (mem_en) addrq.push_back(mem_addr);
    if (done) dcnt <= dcnt + 1;
    if (tx_start && prev_ts) b2b <= b2b + 1;
    prev_ts <= tx_start;
  end

  always @(negedge clk) begin
    if (done && busy) ovl <= ovl + 1;
    if (busy && mem_addr != 10'd0) anz <= anz + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input string tag, input string exp);
    chk({tag, " nbytes"}, 32'(rxq.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len() && i < rxq.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), 32'(rxq[i]), 32'(exp[i]));
  endtask

  task automatic kick(input logic [10:0] l);
    @(negedge clk);
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, n;
    d0 = dcnt;
    n  = 0;
    while (dcnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, 32'(dcnt), 32'(d0 + 1));
    repeat (5) @(negedge clk);
    chk({tag, " one done pulse"}, 32'(dcnt), 32'(d0 + 1));
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic clear_caps;
    rxq.delete();
    addrq.delete();
  endtask

  initial begin
    string s;
    int bad, a0, n;
    resetn = 1'b0;
    start  = 1'b0;
    len    = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst mem_en", 32'(mem_en), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst tx_start", 32'(tx_start), 0);
    chk("rst tx_data", 32'(tx_data), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // len=3, {0,9,10}, with start-to-first-byte timing
    mem[0] = 8'd0; mem[1] = 8'd9; mem[2] = 8'd10;
    clear_caps();
    kick(11'd3);
    chk("t1 c1 busy", 32'(busy), 1);
    chk("t1 c1 mem_en", 32'(mem_en), 1);
    chk("t1 c1 mem_addr", 32'(mem_addr), 0);
    chk("t1 c1 tx_start", 32'(tx_start), 0);
    @(negedge clk);
    chk("t1 c2 mem_en", 32'(mem_en), 0);
    chk("t1 c2 tx_start", 32'(tx_start), 0);
    @(negedge clk);
    chk("t1 c3 tx_start", 32'(tx_start), 1);
    chk("t1 c3 tx_data", 32'(tx_data), 32'h30);
    wait_done("t1", 2000);
    chk_stream("t1", "0\n9\n10\nD\n");
    chk("t1 nreads", 32'(addrq.size()), 3);
    for (int i = 0; i < addrq.size(); i++) chk($sformatf("t1 addr%0d", i), 32'(addrq[i]), 32'(i));

    // len=1, 255; mem_addr held at 0
    mem[0] = 8'd255;
    clear_caps();
    a0 = anz;
    kick(11'd1);
    wait_done("t2", 1000);
    chk_stream("t2", "255\nD\n");
    chk("t2 addr nonzero cycles", 32'(anz - a0), 0);

    // len=0: trailer only, no reads
    clear_caps();
    kick(11'd0);
    wait_done("t3", 500);
    chk_stream("t3", "D\n");
    chk("t3 nreads", 32'(addrq.size()), 0);

    // len=2000 clamps to 1024, ramp pattern
    busy_len = 2;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i % 256);
    clear_caps();
    kick(11'd2000);
    wait_done("t4", 60000);
    s = "";
    for (int i = 0; i < 1024; i++) s = {s, $sformatf("%0d\n", i % 256)};
    s = {s, "D\n"};
    chk_stream("t4", s);
    chk("t4 nreads", 32'(addrq.size()), 1024);
    bad = 0;
    for (int i = 0; i < addrq.size(); i++) if (addrq[i] != 10'(i)) bad++;
    chk("t4 addr order", 32'(bad), 0);

    // extra starts ignored while busy, short UART busy
    busy_len = 5;
    mem[0] = 8'd42; mem[1] = 8'd200;
    clear_caps();
    kick(11'd2);
    repeat (4) @(negedge clk);
    chk("t5 busy at extra start", 32'(busy), 1);
    start = 1'b1; len = 11'd1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    start = 1'b1; len = 11'd0;
    @(negedge clk); start = 1'b0;
    wait_done("t5", 2000);
    chk_stream("t5", "42\n200\nD\n");
    chk("t5 nreads", 32'(addrq.size()), 2);
    chk("t5 back-to-back tx_start", 32'(b2b), 0);

    // async reset during third char of first value, then a clean dump
    busy_len = 20;
    mem[0] = 8'd123; mem[1] = 8'd7;
    clear_caps();
    kick(11'd2);
    n = 0;
    while (rxq.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t6 reached third char", 32'(rxq.size()), 3);
    #2 resetn = 1'b0;
    #1;
    chk("t6 async busy", 32'(busy), 0);
    chk("t6 async done", 32'(done), 0);
    chk("t6 async mem_en", 32'(mem_en), 0);
    chk("t6 async mem_addr", 32'(mem_addr), 0);
    chk("t6 async tx_start", 32'(tx_start), 0);
    chk("t6 async tx_data", 32'(tx_data), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    clear_caps();
    kick(11'd2);
    wait_done("t6", 2000);
    chk_stream("t6", "123\n7\nD\n");
    chk("t6 nreads", 32'(addrq.size()), 2);
    if (addrq.size() > 0) chk("t6 first addr", 32'(addrq[0]), 0);

    chk("done with busy high", 32'(ovl), 0);
    chk("back-to-back tx_start total", 32'(b2b), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
